// File: rtl/cv32e40p_register_file_scrubber.sv
// Queues ECC-corrected register words flagged by the read-port decoders and writes them back through port B.
// Latency: 1 cycle from fault to scrub_we_o on an empty queue; request is held stable until scrub_gnt_i accepts it.
module cv32e40p_register_file_scrubber #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  input  logic [DATA_WIDTH-1:0] rdata_a_i,
  input  logic [DATA_WIDTH-1:0] rdata_b_i,
  input  logic [DATA_WIDTH-1:0] rdata_c_i,
  input  logic                  fault_a_i,
  input  logic                  fault_b_i,
  input  logic                  fault_c_i,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] waddr_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] waddr_b_i,
  input  logic                  scrub_gnt_i,
  output logic                  scrub_we_o,
  output logic [ADDR_WIDTH-1:0] scrub_waddr_o,
  output logic [DATA_WIDTH-1:0] scrub_wdata_o,
  input  logic                  clear_i,
  output logic [CNT_WIDTH-1:0]  fault_count_o,
  output logic                  drop_o,
  output logic                  pending_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CNT_WIDTH + 2;

  typedef enum logic {IDLE, REQ} state_e;
  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d, cancel;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]         occ_q, occ_d, free, n_enq;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  drop_q, drop_d;

  logic [ADDR_WIDTH-1:0] cand_addr [3];
  logic [DATA_WIDTH-1:0] cand_data [3];
  logic [2:0]            cand_flt, flt_ok, enq_req;
  logic [1:0]            n_flt;
  logic [SW-1:0]         cnt_sum;
  logic                  head_live, accept, pop, overflow;

  assign cand_addr[0] = raddr_a_i;
  assign cand_addr[1] = raddr_b_i;
  assign cand_addr[2] = raddr_c_i;
  assign cand_data[0] = rdata_a_i;
  assign cand_data[1] = rdata_b_i;
  assign cand_data[2] = rdata_c_i;
  assign cand_flt     = {fault_c_i, fault_b_i, fault_a_i};

  // A core write to a queued address makes that entry obsolete immediately.
  always_comb begin
    cancel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cancel[i] = vld_q[i] & ((we_a_i && (waddr_a_i == addr_q[i])) ||
                              (we_b_i && (waddr_b_i == addr_q[i])));
    end
  end

  assign head_live  = vld_q[rd_ptr_q] & ~cancel[rd_ptr_q];
  assign scrub_we_o = (state_q == REQ) & head_live;
  assign accept     = scrub_we_o & scrub_gnt_i;
  // Dead (cancelled) heads are popped without a write.
  assign pop        = (occ_q != '0) & (accept | ~head_live);

  always_comb begin
    flt_ok  = '0;
    enq_req = '0;
    n_flt   = '0;
    for (int p = 0; p < 3; p++) begin
      flt_ok[p] = cand_flt[p] && (cand_addr[p] != '0) &&
                  !(we_a_i && (waddr_a_i == cand_addr[p])) &&
                  !(we_b_i && (waddr_b_i == cand_addr[p]));
      n_flt      = n_flt + 2'(flt_ok[p]);
      enq_req[p] = flt_ok[p];
      for (int q = 0; q < p; q++) begin
        if (flt_ok[q] && (cand_addr[q] == cand_addr[p])) enq_req[p] = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (addr_q[i] == cand_addr[p])) enq_req[p] = 1'b0;
      end
    end
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    vld_d  = vld_q & ~cancel;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    // A slot freed by this cycle's pop is reusable immediately.
    free     = OW'(DEPTH) - occ_q + OW'(pop);
    wr_ptr_d = wr_ptr_q;
    n_enq    = '0;
    overflow = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (enq_req[p]) begin
        if (n_enq < free) begin
          addr_d[wr_ptr_d] = cand_addr[p];
          data_d[wr_ptr_d] = cand_data[p];
          vld_d[wr_ptr_d]  = 1'b1;
          wr_ptr_d         = wr_ptr_d + 1'b1;
          n_enq            = n_enq + 1'b1;
        end else begin
          overflow = 1'b1;
        end
      end
    end
    occ_d   = occ_q - OW'(pop) + n_enq;
    cnt_sum = {2'b00, cnt_q} + SW'(n_flt);
    cnt_d   = clear_i ? '0 : ((cnt_sum[SW-1:CNT_WIDTH] != '0) ? '1 : cnt_sum[CNT_WIDTH-1:0]);
    drop_d  = clear_i ? 1'b0 : (drop_q | overflow);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (vld_d != '0) state_d = REQ;
      REQ:     if (vld_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign scrub_waddr_o = addr_q[rd_ptr_q];
  assign scrub_wdata_o = data_q[rd_ptr_q];
  assign fault_count_o = cnt_q;
  assign drop_o        = drop_q;
  assign pending_o     = |vld_q;

endmodule

// File: tb/tb_cv32e40p_register_file_scrubber.sv
// Directed bench for the register file scrubber; expected write-backs go to a queue checked by a monitor.
module tb_cv32e40p_register_file_scrubber;

  logic        clk, rst_n;
  logic [5:0]  raddr_a, raddr_b, raddr_c, waddr_a, waddr_b, scrub_waddr;
  logic [31:0] rdata_a, rdata_b, rdata_c, scrub_wdata;
  logic        fault_a, fault_b, fault_c, we_a, we_b, gnt, scrub_we, clear, drop, pending;
  logic [7:0]  fault_count;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  cv32e40p_register_file_scrubber dut (
    .clk(clk), .rst_n(rst_n),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .rdata_a_i(rdata_a), .rdata_b_i(rdata_b), .rdata_c_i(rdata_c),
    .fault_a_i(fault_a), .fault_b_i(fault_b), .fault_c_i(fault_c),
    .we_a_i(we_a), .waddr_a_i(waddr_a), .we_b_i(we_b), .waddr_b_i(waddr_b),
    .scrub_gnt_i(gnt), .scrub_we_o(scrub_we), .scrub_waddr_o(scrub_waddr),
    .scrub_wdata_o(scrub_wdata), .clear_i(clear), .fault_count_o(fault_count),
    .drop_o(drop), .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted scrub write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && scrub_we && gnt) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h, required no write", scrub_waddr, scrub_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(scrub_waddr), 32'(e.addr));
        chk("write_data", scrub_wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    fault_a = 0; fault_b = 0; fault_c = 0;
    raddr_a = 0; raddr_b = 0; raddr_c = 0;
    rdata_a = 0; rdata_b = 0; rdata_c = 0;
    we_a = 0; we_b = 0; waddr_a = 0; waddr_b = 0; clear = 0;
  endtask

  task automatic rd(input int p, input logic [5:0] a, input logic [31:0] d);
    case (p)
      0: begin fault_a = 1; raddr_a = a; rdata_a = d; end
      1: begin fault_b = 1; raddr_b = a; rdata_b = d; end
      default: begin fault_c = 1; raddr_c = a; rdata_c = d; end
    endcase
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},      32'(scrub_we), 0);
    chk({tag, "_waddr"},   32'(scrub_waddr), 0);
    chk({tag, "_wdata"},   scrub_wdata, 0);
    chk({tag, "_count"},   32'(fault_count), 0);
    chk({tag, "_drop"},    32'(drop), 0);
    chk({tag, "_pending"}, 32'(pending), 0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    gnt = 1;
    idle_in();
    #12;
    chk_reset_outputs("reset");
    rst_n = 1;
    tick();

    // Single fault, minimum latency, one-cycle write
    rd(0, 6'd5, 32'hDEADBEEF);
    push(6'd5, 32'hDEADBEEF);
    tick();
    idle_in();
    chk("single_we", 32'(scrub_we), 1);
    chk("single_waddr", 32'(scrub_waddr), 5);
    chk("single_count", 32'(fault_count), 1);
    tick();
    chk("single_we_drop", 32'(scrub_we), 0);
    chk("single_pending", 32'(pending), 0);

    // Same address on all three ports: one write, three counts
    for (int p = 0; p < 3; p++) rd(p, 6'd7, 32'h12345678);
    push(6'd7, 32'h12345678);
    tick();
    idle_in();
    chk("dedup_count", 32'(fault_count), 4);
    chk("dedup_waddr", 32'(scrub_waddr), 7);
    tick();
    chk("dedup_we_after", 32'(scrub_we), 0);

    // Backpressure: request held stable while grant is low
    gnt = 0;
    rd(0, 6'd3, 32'hA5A50003);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("bp_we", 32'(scrub_we), 1);
      chk("bp_waddr", 32'(scrub_waddr), 3);
      chk("bp_wdata", scrub_wdata, 32'hA5A50003);
      tick();
    end
    push(6'd3, 32'hA5A50003);
    gnt = 1;
    tick();
    chk("bp_we_after", 32'(scrub_we), 0);
    chk("bp_pending", 32'(pending), 0);
    chk("bp_count", 32'(fault_count), 5);

    // Cancel by a core write to the pending address
    gnt = 0;
    rd(0, 6'd9, 32'h00000099);
    tick();
    idle_in();
    chk("cancel_pre_we", 32'(scrub_we), 1);
    we_a = 1; waddr_a = 6'd9;
    #1;
    chk("cancel_we_masked", 32'(scrub_we), 0);
    tick();
    idle_in();
    chk("cancel_pending", 32'(pending), 0);
    gnt = 1;
    tick();
    tick();
    chk("cancel_we_after", 32'(scrub_we), 0);

    // Stale fault: core writes the same address this cycle
    rd(0, 6'd12, 32'h0000C0DE);
    we_b = 1; waddr_b = 6'd12;
    tick();
    idle_in();
    chk("stale_pending", 32'(pending), 0);
    chk("stale_count", 32'(fault_count), 6);

    // Full queue, pop and enqueue in the same cycle
    gnt = 0;
    rd(0, 6'd1, 32'h11);
    rd(1, 6'd2, 32'h22);
    tick();
    idle_in();
    gnt = 1;
    rd(0, 6'd10, 32'hAA);
    push(6'd1, 32'h11);
    push(6'd2, 32'h22);
    push(6'd10, 32'hAA);
    tick();
    idle_in();
    tick();
    tick();
    chk("fullpop_pending", 32'(pending), 0);
    chk("fullpop_drop", 32'(drop), 0);
    chk("fullpop_count", 32'(fault_count), 9);

    // Overflow while full; address-0 fault ignored
    gnt = 0;
    rd(0, 6'd1, 32'h11);
    rd(1, 6'd2, 32'h22);
    tick();
    idle_in();
    rd(0, 6'd4, 32'h44);
    rd(1, 6'd0, 32'h0);
    tick();
    idle_in();
    chk("ovf_drop", 32'(drop), 1);
    chk("ovf_count", 32'(fault_count), 12);
    push(6'd1, 32'h11);
    push(6'd2, 32'h22);
    gnt = 1;
    tick();
    tick();
    chk("ovf_pending", 32'(pending), 0);
    clear = 1;
    tick();
    clear = 0;
    chk("clear_drop", 32'(drop), 0);
    chk("clear_count", 32'(fault_count), 0);

    // Saturation: 3 faults per cycle for 100 cycles
    gnt = 0;
    for (int p = 0; p < 3; p++) rd(p, 6'd20, 32'h2020);
    for (int i = 0; i < 84; i++) tick();
    chk("sat_count_252", 32'(fault_count), 252);
    for (int i = 0; i < 16; i++) tick();
    idle_in();
    chk("sat_count_255", 32'(fault_count), 255);
    chk("sat_we_held", 32'(scrub_we), 1);
    chk("sat_waddr", 32'(scrub_waddr), 20);

    // Asynchronous reset during REQ drops everything
    #2;
    rst_n = 0;
    #1;
    chk_reset_outputs("midreset");
    tick();
    tick();
    rst_n = 1;
    gnt = 1;
    tick();
    tick();
    tick();
    chk("postreset_we", 32'(scrub_we), 0);
    chk("postreset_pending", 32'(pending), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
